// File: rtl/intellight_pkg.sv
// Shared IntelLight constants: action encoding {dur, road} and scan FSM states.
package intellight_pkg;

    localparam int N_ROAD       = 4;
    localparam int A_ROAD_WIDTH = 2;
    localparam int A_DUR_WIDTH  = 2;
    localparam int N_LEVEL      = 2 ** A_DUR_WIDTH;
    localparam int A_WIDTH      = A_ROAD_WIDTH + A_DUR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/q_argmax_acc.sv
// Signed running max/argmax; init loads unconditionally, ties keep the lower index.
module q_argmax_acc #(
    parameter int Q_WIDTH = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               init,
    input  logic [A_WIDTH-1:0] idx,
    input  logic [Q_WIDTH-1:0] val,
    output logic [Q_WIDTH-1:0] nxt_q,
    output logic [A_WIDTH-1:0] nxt_a
);

    logic [Q_WIDTH-1:0] max_q;
    logic [A_WIDTH-1:0] max_a;
    logic               take;

    // Indices arrive ascending, so strict '>' resolves ties to the lowest.
    assign take  = en && (init || ($signed(val) > $signed(max_q)));
    assign nxt_q = take ? val : max_q;
    assign nxt_a = take ? idx : max_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            max_a <= '0;
        end else if (en) begin
            max_q <= nxt_q;
            max_a <= nxt_a;
        end
    end

endmodule

// File: rtl/q_max_search.sv
// Q-table scan: reads all actions of a state, reports max, argmax, selected Q
// and the per-level Q vector of the argmax road.
module q_max_search
    import intellight_pkg::*;
#(
    parameter int S_WIDTH = 8,
    parameter int L_WIDTH = 4,
    parameter int Q_WIDTH = 16,
    parameter int RD_LAT  = 1,
    localparam int DW     = L_WIDTH / 2,
    localparam int AW     = A_ROAD_WIDTH + DW,
    localparam int NLV    = 2 ** DW,
    localparam int NA     = 2 ** AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [S_WIDTH-1:0]     S,
    input  logic [AW-1:0]          A_in,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [S_WIDTH+AW-1:0]  rd_addr,
    input  logic [Q_WIDTH-1:0]     rd_data,
    output logic [Q_WIDTH-1:0]     Q_max,
    output logic [Q_WIDTH-1:0]     Q_sel,
    output logic [AW-1:0]          A_max,
    output logic [Q_WIDTH*NLV-1:0] D
);

    state_t             state;
    logic [S_WIDTH-1:0] s_lat;
    logic [AW-1:0]      a_lat;
    logic [AW-1:0]      a;
    logic [AW-1:0]      a_nxt;
    logic [1:0]         dcnt;

    logic [RD_LAT-1:0]  vld;
    logic [AW-1:0]      pidx [RD_LAT];
    logic               t_vld;
    logic [AW-1:0]      t_idx;

    logic [Q_WIDTH-1:0] cap [NA];
    logic [Q_WIDTH-1:0] sel_q;
    logic [Q_WIDTH-1:0] sel_nxt;
    logic [Q_WIDTH-1:0] max_nxt;
    logic [AW-1:0]      arg_nxt;
    logic [Q_WIDTH*NLV-1:0] d_nxt;
    logic [AW-1:0]      di;

    assign a_nxt = a + AW'(1);
    assign t_vld = vld[RD_LAT-1];
    assign t_idx = pidx[RD_LAT-1];

    // Tag each BRAM return with its action index.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
        end else begin
            vld[0]  <= rd_en;
            pidx[0] <= rd_addr[AW-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i]  <= vld[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (t_vld) cap[t_idx] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) sel_q <= '0;
        else if (t_vld && t_idx == a_lat) sel_q <= rd_data;
    end

    q_argmax_acc #(
        .Q_WIDTH (Q_WIDTH),
        .A_WIDTH (AW)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .en    (t_vld),
        .init  (t_idx == '0),
        .idx   (t_idx),
        .val   (rd_data),
        .nxt_q (max_nxt),
        .nxt_a (arg_nxt)
    );

    // The final return lands on the same edge as the result update: bypass it.
    always_comb begin
        sel_nxt = (t_vld && t_idx == a_lat) ? rd_data : sel_q;
        d_nxt   = '0;
        di      = '0;
        for (int d = 0; d < NLV; d++) begin
            di = {DW'(d), arg_nxt[A_ROAD_WIDTH-1:0]};
            d_nxt[d*Q_WIDTH +: Q_WIDTH] =
                (t_vld && t_idx == di) ? rd_data : cap[di];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            Q_max   <= '0;
            Q_sel   <= '0;
            A_max   <= '0;
            D       <= '0;
            s_lat   <= '0;
            a_lat   <= '0;
            a       <= '0;
            dcnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s_lat   <= S;
                        a_lat   <= A_in;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= {S, AW'(0)};
                        a       <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (a == AW'(NA - 1)) begin
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        a       <= a_nxt;
                        rd_addr <= {s_lat, a_nxt};
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(RD_LAT - 1)) begin
                        Q_max <= max_nxt;
                        A_max <= arg_nxt;
                        Q_sel <= sel_nxt;
                        D     <= d_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_max_search.sv
// Directed bench: two scan engines (read latency 1 and 2) sharing one Q-table model.
module tb_q_max_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  S = '0;
    logic [3:0]  A_in = '0;

    logic        busy1, done1, rd_en1;
    logic [11:0] rd_addr1;
    logic [15:0] rd_data1, Q_max1, Q_sel1;
    logic [3:0]  A_max1;
    logic [63:0] D1;

    logic        busy2, done2, rd_en2;
    logic [11:0] rd_addr2;
    logic [15:0] rd_data2, Q_max2, Q_sel2;
    logic [3:0]  A_max2;
    logic [63:0] D2;

    logic [15:0] mem [0:4095];
    logic [15:0] r1, r2a, r2b;

    int n_tests = 0;
    int n_fail  = 0;

    int dk1, dk2, nd1, nd2;
    logic [15:0] cq1, cs1, cq2, cs2;
    logic [3:0]  ca1, ca2;
    logic [63:0] cd1, cd2;
    logic        en_k1, en_k16, en_k17;
    logic [11:0] addr_k10;
    logic        r_rden1, r_rden2, r_busy;
    logic [15:0] r_qmax;
    logic [3:0]  r_amax;
    logic [63:0] r_d;
    logic [15:0] hold_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en1) r1 <= mem[rd_addr1];
        if (rd_en2) r2a <= mem[rd_addr2];
        r2b <= r2a;
    end
    assign rd_data1 = r1;
    assign rd_data2 = r2b;

    q_max_search #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .S(S), .A_in(A_in),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .Q_max(Q_max1), .Q_sel(Q_sel1),
        .A_max(A_max1), .D(D1)
    );

    q_max_search #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .S(S), .A_in(A_in),
        .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .Q_max(Q_max2), .Q_sel(Q_sel2),
        .A_max(A_max2), .D(D2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input logic [7:0] s, input logic [3:0] a,
                            input bit disturb, input int rst_k);
        dk1 = 0; dk2 = 0; nd1 = 0; nd2 = 0;
        @(negedge clk);
        start = 1'b1; S = s; A_in = a;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done1) begin
                nd1++;
                if (dk1 == 0) begin
                    dk1 = k; cq1 = Q_max1; cs1 = Q_sel1; ca1 = A_max1; cd1 = D1;
                end
            end
            if (done2) begin
                nd2++;
                if (dk2 == 0) begin
                    dk2 = k; cq2 = Q_max2; cs2 = Q_sel2; ca2 = A_max2; cd2 = D2;
                end
            end
            if (k == 1)  en_k1  = rd_en1;
            if (k == 16) en_k16 = rd_en1;
            if (k == 17) en_k17 = rd_en1;
            if (k == 10) addr_k10 = rd_addr1;
            if (k == 40) hold_q = Q_max1;
            if (disturb && k == 5) begin start = 1'b1; S = s + 8'd1; end
            if (disturb && k == 6) start = 1'b0;
            if (rst_k != 0 && k == rst_k + 1) begin
                r_rden1 = rd_en1; r_rden2 = rd_en2; r_busy = busy1 | busy2;
                r_qmax = Q_max1; r_amax = A_max1; r_d = D1;
                rst = 1'b0;
            end
            if (rst_k != 0 && k == rst_k) rst = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            mem[{8'd5, 4'(i)}] = 16'(i * 10);
            mem[{8'd6, 4'(i)}] = 16'(1000 - i);
            mem[{8'd7, 4'(i)}] = 16'hFF9C;
            mem[{8'd2, 4'(i)}] = 16'h8000;
        end
        mem[{8'd7, 4'd2}]  = 16'hFFCE;
        mem[{8'd7, 4'd6}]  = 16'hFFFB;
        mem[{8'd7, 4'd10}] = 16'hFFFB;
        mem[{8'd7, 4'd14}] = 16'hFFBA;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {busy1, done1, rd_en1, busy2, done2, rd_en2}, 64'h0);
        chk("rst_addr", rd_addr1, 64'h0);
        chk("rst_out", {Q_max1, Q_sel1, A_max1}, 64'h0);
        chk("rst_d", D1, 64'h0);

        // ramp: max at last action
        run_scan(8'd5, 4'd3, 1'b0, 0);
        chk("ramp_done_lat1", dk1, 18);
        chk("ramp_done_lat2", dk2, 19);
        chk("ramp_ndone", nd1 + nd2, 2);
        chk("ramp_rden", {en_k1, en_k16, en_k17}, 64'b110);
        chk("ramp_amax1", ca1, 15);
        chk("ramp_qmax1", cq1, 150);
        chk("ramp_qsel1", cs1, 30);
        chk("ramp_d1", cd1, {16'd150, 16'd110, 16'd70, 16'd30});
        chk("ramp_all2", {ca2, cq2, cs2}, {4'd15, 16'd150, 16'd30});
        chk("ramp_d2", cd2, {16'd150, 16'd110, 16'd70, 16'd30});
        chk("ramp_hold", hold_q, 150);

        // negative values, tie between 6 and 10
        run_scan(8'd7, 4'd10, 1'b0, 0);
        chk("neg_amax1", ca1, 6);
        chk("neg_qmax1", cq1, 16'hFFFB);
        chk("neg_qsel1", cs1, 16'hFFFB);
        chk("neg_d1", cd1, 64'hFFBA_FFFB_FFFB_FFCE);
        chk("neg_amax2", ca2, 6);
        chk("neg_d2", cd2, 64'hFFBA_FFFB_FFFB_FFCE);

        // all-equal most negative
        run_scan(8'd2, 4'd0, 1'b0, 0);
        chk("eq_amax1", ca1, 0);
        chk("eq_qmax1", cq1, 16'h8000);
        chk("eq_d1", cd1, 64'h8000_8000_8000_8000);
        chk("eq_amax2", {ca2, cq2}, {4'd0, 16'h8000});

        // start + S change during busy
        run_scan(8'd5, 4'd0, 1'b1, 0);
        chk("busy_ndone1", nd1, 1);
        chk("busy_ndone2", nd2, 1);
        chk("busy_addr", addr_k10, 12'h059);
        chk("busy_amax", ca1, 15);
        chk("busy_qsel", cs1, 0);

        // reset at the 8th issue cycle
        run_scan(8'd7, 4'd1, 1'b0, 8);
        chk("rst_mid_ndone", nd1 + nd2, 0);
        chk("rst_mid_rden", {r_rden1, r_rden2, r_busy}, 64'h0);
        chk("rst_mid_out", {r_qmax, r_amax}, 64'h0);
        chk("rst_mid_d", r_d, 64'h0);

        run_scan(8'd5, 4'd3, 1'b0, 0);
        chk("rescan_done", dk1, 18);
        chk("rescan_out", {ca1, cq1, cs1}, {4'd15, 16'd150, 16'd30});
        chk("rescan_out2", {ca2, cq2, cs2}, {4'd15, 16'd150, 16'd30});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
